// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the demux scan sequencer.
package demux_scan_pkg;

    localparam int unsigned N_OUT = 16;
    localparam int unsigned SEL_W = 4;

    // First index of each direction; each is also the last index of the other direction.
    localparam logic [SEL_W-1:0] SEL_FIRST_ASC  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_FIRST_DESC = SEL_W'(15);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] sel_first(input logic dir);
        return dir ? SEL_FIRST_DESC : SEL_FIRST_ASC;
    endfunction

    function automatic logic [SEL_W-1:0] sel_last(input logic dir);
        return dir ? SEL_FIRST_ASC : SEL_FIRST_DESC;
    endfunction

endpackage

// File: rtl/demux1_16_oh.sv
// Combinational 1-to-16 demux: routes d_bit to position sel and flags that position for write.
module demux1_16_oh
    import demux_scan_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             d_bit,
    input  logic             en,
    output logic [N_OUT-1:0] data,
    output logic [N_OUT-1:0] we
);

    always_comb begin
        data = '0;
        we   = '0;
        if (en) begin
            data[sel] = d_bit;
            we[sel]   = 1'b1;
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Timed scan of a captured 16-bit word into the LED hold register, one position per step.
// Optional step prescaler enabled by defining DEMUX_SCAN_PRESCALE_EN.
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [N_OUT-1:0] data_in,
    input  logic             dir,
    input  logic             loop,
    output logic [N_OUT-1:0] led_out,
    output logic [SEL_W-1:0] sel,
    output logic             d_bit,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [N_OUT-1:0] shadow;
    logic             dir_r;
    logic             loop_r;
    logic             tick;
    logic             at_last;
    logic             capture;
    logic             write_en;
    logic             advance;
    logic             wrap;
    logic             abort;
    logic [N_OUT-1:0] oh_data;
    logic [N_OUT-1:0] oh_we;

    assign busy    = (state == STEP);
    assign done    = (state == DONE);
    assign d_bit   = shadow[sel];
    assign at_last = (sel == sel_last(dir_r));

`ifdef DEMUX_SCAN_PRESCALE_EN
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    // Step prescaler: free-runs only while scanning, restarts on start and stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (capture || abort) begin
            count <= '0;
        end else if (busy) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    demux1_16_oh u_demux (
        .sel   (sel),
        .d_bit (d_bit),
        .en    (tick & busy),
        .data  (oh_data),
        .we    (oh_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes; stop outranks a same-cycle tick.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        write_en   = 1'b0;
        advance    = 1'b0;
        wrap       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    capture    = 1'b1;
                    state_next = STEP;
                end
            end
            STEP: begin
                if (stop) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (tick) begin
                    write_en = 1'b1;
                    if (!at_last) begin
                        advance = 1'b1;
                    end else if (loop_r) begin
                        wrap = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel     <= '0;
            led_out <= '0;
            shadow  <= '0;
            dir_r   <= 1'b0;
            loop_r  <= 1'b0;
        end else begin
            if (capture) begin
                shadow  <= data_in;
                dir_r   <= dir;
                loop_r  <= loop;
                led_out <= '0;
                sel     <= sel_first(dir);
            end else begin
                if (write_en) begin
                    led_out <= (led_out & ~oh_we) | oh_data;
                end
                // Wrap is explicit; the word is refreshed live for the next pass.
                if (wrap) begin
                    sel    <= sel_first(dir_r);
                    shadow <= data_in;
                end else if (advance) begin
                    sel <= dir_r ? sel - SEL_W'(1) : sel + SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Randomized self-checking bench for demux_scan_ctrl against a pass/mask reference model.
module tb_demux_scan_ctrl;

    localparam int unsigned TDIV = 4;
`ifdef DEMUX_SCAN_PRESCALE_EN
    localparam int unsigned P = TDIV;
`else
    localparam int unsigned P = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] data_in;
    logic        dir;
    logic        loop;
    logic [15:0] led_out;
    logic [3:0]  sel;
    logic        d_bit;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_scan_ctrl #(.TICK_DIV(TDIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .data_in (data_in),
        .dir     (dir),
        .loop    (loop),
        .led_out (led_out),
        .sel     (sel),
        .d_bit   (d_bit),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Positions already written after k steps of a pass starting from a cleared bank.
    function automatic logic [15:0] wmask(input logic dr, input int k);
        logic [31:0] m;
        m = (32'd1 << k) - 32'd1;
        if (dr) m = m << (16 - k);
        return 16'(m);
    endfunction

    // Index of the k-th position visited in a pass (k = 0 is the first).
    function automatic logic [3:0] pos(input logic dr, input int k);
        return dr ? 4'(15 - k) : 4'(k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next write edge, confirming the block stays busy in between.
    task automatic wait_write();
        for (int c = 1; c <= int'(P); c++) begin
            step();
            if (c < int'(P)) check("mid_busy", busy, 1);
        end
    endtask

    task automatic launch(input logic [15:0] d, input logic dr, input logic lp);
        data_in = d;
        dir     = dr;
        loop    = lp;
        start   = 1'b1;
        step();
        start   = 1'b0;
        data_in = 16'($urandom);
        check("start_busy", busy, 1);
        check("start_sel", sel, pos(dr, 0));
        check("start_led", led_out, 0);
        check("start_done", done, 0);
    endtask

    task automatic single_pass(input logic [15:0] d, input logic dr, input logic glitch);
        launch(d, dr, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (glitch && k == 9) begin
                start   = 1'b1;
                data_in = ~d;
                dir     = ~dr;
            end
            wait_write();
            start = 1'b0;
            check("led", led_out, d & wmask(dr, k));
            if (k < 16) begin
                check("sel", sel, pos(dr, k));
                check("d_bit", d_bit, d[pos(dr, k)]);
                check("busy", busy, 1);
                check("done_early", done, 0);
            end
        end
        check("end_sel", sel, pos(dr, 15));
        check("done_pulse", done, 1);
        check("end_busy", busy, 0);
        if (glitch) start = 1'b1;
        step();
        check("done_drop", done, 0);
        check("idle_busy", busy, 0);
        check("hold_led", led_out, d);
        start = 1'b0;
        step();
        check("no_restart", busy, 0);
        check("hold_led2", led_out, d);
    endtask

    task automatic loop_test(input logic [15:0] d0, input logic [15:0] d1, input logic dr);
        logic [15:0] m;
        logic [15:0] word;
        launch(d0, dr, 1'b1);
        data_in = d0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 16; k++) begin
                if (pass == 0 && k == 8) data_in = d1;
                wait_write();
                m    = wmask(dr, k);
                word = (pass == 0) ? d0 : d1;
                if (pass == 0) check("loop_led1", led_out, d0 & m);
                else           check("loop_led2", led_out, (d1 & m) | (d0 & ~m));
                check("loop_done", done, 0);
                check("loop_busy", busy, 1);
                if (k < 16) begin
                    check("loop_sel", sel, pos(dr, k));
                    check("loop_dbit", d_bit, word[pos(dr, k)]);
                end else begin
                    check("loop_wrap", sel, pos(dr, 0));
                    check("loop_refresh", d_bit, d1[pos(dr, 0)]);
                end
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("loop_stop_busy", busy, 0);
        check("loop_stop_done", done, 0);
        check("loop_stop_led", led_out, d1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        data_in = '0;
        dir     = 1'b0;
        loop    = 1'b0;
        #12;
        check("rst_led", led_out, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbit", d_bit, 0);
        rst = 1'b0;
        step();

        single_pass(16'hA5C3, 1'b0, 1'b0);
        single_pass(16'hA5C3, 1'b1, 1'b0);

        // Abort after the 5th write keeps the partial result.
        launch(16'hFFFF, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) wait_write();
        check("stop_pre_led", led_out, 16'h001F);
        stop = 1'b1;
        step();
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_led", led_out, 16'h001F);
        stop = 1'b0;
        step();
        check("stop_done2", done, 0);
        check("stop_led2", led_out, 16'h001F);

        start = 1'b1;
        stop  = 1'b1;
        step();
        check("start_stop_idle", busy, 0);
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset in the middle of a scan.
        launch(16'($urandom), 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) wait_write();
        check("pre_rst_sel", sel, 7);
        #2 rst = 1'b1;
        #1;
        check("arst_led", led_out, 0);
        check("arst_sel", sel, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        #1 rst = 1'b0;
        step();
        single_pass(16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        loop_test(16'hA5C3, 16'h0F0F, 1'b0);
        loop_test(16'($urandom) | 16'h8001, 16'h0F0F, 1'b1);

        for (int i = 0; i < 6; i++) begin
            single_pass(16'($urandom), 1'($urandom_range(0, 1)), 1'(i % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
